// File: rtl/seg7_scan_decoder_pkg.sv
// Shared constants and types for the 7-segment scan decoder: glyph table,
// blank/decimal-point encodings and the sampler's per-edge action type.
package seg7_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int SEG_DP_BIT = 7;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low segment patterns (g..a) produced by the display encoder
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h18;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  localparam logic [6:0] GLYPH_TABLE [16] = '{
    GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7,
    GLYPH_8, GLYPH_9, GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F
  };

  typedef enum logic [1:0] {
    SAMPLE_BAD,
    SAMPLE_NEW,
    SAMPLE_COUNT,
    SAMPLE_HOLD
  } sampleAction_e;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Scan-bus and readback signals between the display pins and the decoder.
interface seg7_scan_decoder_if;
  import seg7_pkg::*;

  logic [7:0]              iSEG;
  logic [NUM_DIGITS-1:0]   iSEL;
  logic [4*NUM_DIGITS-1:0] oDIG;
  logic [NUM_DIGITS-1:0]   oDP;
  logic [NUM_DIGITS-1:0]   oERR;
  logic                    oVALID;

  modport master (output iSEG, iSEL, input oDIG, oDP, oERR, oVALID);
  modport slave  (input iSEG, iSEL, output oDIG, oDP, oERR, oVALID);

endinterface

// File: rtl/seg7_scan_decoder_dec.sv
// Combinational inverse of the hex-to-segment encoder; anything outside the
// sixteen glyphs is flagged illegal and reported as nibble 0.
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       illegal
);

  always_comb begin
    nibble  = '0;
    illegal = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (pattern == GLYPH_TABLE[i]) begin
        nibble  = 4'(i);
        illegal = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus, accepting a
// digit once select and segments have been stable for STABLE_CNT samples.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input logic              iCLK,
  input logic              iRST_N,
  seg7_scan_decoder_if.slave bus
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

  logic [NUM_DIGITS-1:0]   heldSel;
  logic [7:0]              heldSeg;
  logic [CNT_W-1:0]        cnt;
  logic [NUM_DIGITS-1:0]   seen;
  logic [4*NUM_DIGITS-1:0] digReg;
  logic [NUM_DIGITS-1:0]   dpReg;
  logic [NUM_DIGITS-1:0]   errReg;
  logic                    validReg;

  sampleAction_e         action;
  logic                  accept;
  logic                  frameDone;
  logic [NUM_DIGITS-1:0] seenMerged;
  logic [3:0]            decNibble;
  logic                  decIllegal;

  seg7_dec uDec (
    .pattern (bus.iSEG[6:0]),
    .nibble  (decNibble),
    .illegal (decIllegal)
  );

  // The accept fires on the edge that brings the counter up to STABLE_CNT,
  // so the registered outputs land on that same edge.
  always_comb begin
    action = SAMPLE_BAD;
    if (!$onehot(bus.iSEL)) begin
      action = SAMPLE_BAD;
    end else if ({bus.iSEL, bus.iSEG} != {heldSel, heldSeg}) begin
      action = SAMPLE_NEW;
    end else if (cnt < CNT_TOP) begin
      action = SAMPLE_COUNT;
    end else begin
      action = SAMPLE_HOLD;
    end
    accept     = (action == SAMPLE_COUNT) && (cnt == CNT_LAST);
    seenMerged = seen | bus.iSEL;
    frameDone  = accept && (seenMerged == ALL_SEEN);
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      heldSel  <= '0;
      heldSeg  <= SEG_BLANK;
      cnt      <= '0;
      seen     <= '0;
      digReg   <= '0;
      dpReg    <= '0;
      errReg   <= '0;
      validReg <= 1'b0;
    end else begin
      validReg <= frameDone;
      case (action)
        SAMPLE_BAD: begin
          heldSel <= bus.iSEL;
          heldSeg <= bus.iSEG;
          cnt     <= '0;
        end
        SAMPLE_NEW: begin
          heldSel <= bus.iSEL;
          heldSeg <= bus.iSEG;
          cnt     <= CNT_ONE;
        end
        SAMPLE_COUNT: cnt <= cnt + CNT_ONE;
        default: ;
      endcase
      if (accept) begin
        seen <= frameDone ? '0 : seenMerged;
        // An illegal pattern keeps the previous nibble and only raises the error flag
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (bus.iSEL[i]) begin
            if (!decIllegal) begin
              digReg[4*i +: 4] <= decNibble;
            end
            errReg[i] <= decIllegal;
            dpReg[i]  <= ~bus.iSEG[SEG_DP_BIT];
          end
        end
      end
    end
  end

  assign bus.oDIG   = digReg;
  assign bus.oDP    = dpReg;
  assign bus.oERR   = errReg;
  assign bus.oVALID = validReg;

endmodule
